// File: rtl/parachute_pkg.sv
// Shared types and constants for the parachute object controller.
package parachute_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FALL   = 2'd1,
    ST_CAUGHT = 2'd2,
    ST_LANDED = 2'd3
  } obj_state_t;

  localparam int Y_W       = 10;
  localparam int NUM_SLOTS = 4;
  localparam int STEP_W    = 4;
  localparam int MAX_STEP  = 6;

  // Fixed lane X positions, slot 0 in the low word.
  localparam logic [NUM_SLOTS-1:0][Y_W-1:0] LANE_X =
    {10'd560, 10'd400, 10'd240, 10'd80};

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/parachute_obj_ctrl_if.sv
// Spawn/control inputs and sprite/score outputs of the parachute controller.
interface parachute_obj_ctrl_if;
  import parachute_pkg::*;

  logic                   frame_tick;
  logic                   obj0;
  logic                   obj1;
  logic                   obj2;
  logic                   obj3;
  logic                   obj_clear;
  logic                   freeze;
  logic [Y_W-1:0]         player_x;
  logic [2*NUM_SLOTS-1:0] obj_state;
  logic [Y_W*NUM_SLOTS-1:0] obj_y;
  logic [2:0]             score_add;
  logic [2:0]             miss_add;

  modport master (
    output frame_tick, obj0, obj1, obj2, obj3, obj_clear, freeze, player_x,
    input  obj_state, obj_y, score_add, miss_add
  );

  modport slave (
    input  frame_tick, obj0, obj1, obj2, obj3, obj_clear, freeze, player_x,
    output obj_state, obj_y, score_add, miss_add
  );

endinterface

// File: rtl/parachute_obj_slot.sv
// One falling-object slot: IDLE -> FALL -> CAUGHT/LANDED -> hold -> IDLE.
module parachute_obj_slot
  import parachute_pkg::*;
#(
  parameter int CATCH_Y      = 420,
  parameter int FLOOR_Y      = 440,
  parameter int CATCH_HALF_W = 24,
  parameter int HOLD_FRAMES  = 30
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              spawn,
  input  logic              tick,
  input  logic              clear,
  input  logic              freeze,
  input  logic [STEP_W-1:0] step,
  input  logic [Y_W-1:0]    lane_x,
  input  logic [Y_W-1:0]    player_x,
  output obj_state_t        state,
  output logic [Y_W-1:0]    y,
  output logic              catch_pulse,
  output logic              land_pulse
);

  localparam int YX_W   = Y_W + 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [YX_W-1:0]   CATCH_YX  = YX_W'(CATCH_Y);
  localparam logic [YX_W-1:0]   FLOOR_YX  = YX_W'(FLOOR_Y);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  obj_state_t          state_q, state_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [YX_W-1:0]        ny;
  logic signed [YX_W-1:0] diff;
  logic signed [YX_W-1:0] adiff;
  logic                   in_reach;

  always_comb begin
    ny       = {1'b0, y_q} + YX_W'(step);
    diff     = $signed({1'b0, lane_x}) - $signed({1'b0, player_x});
    adiff    = diff[YX_W-1] ? -diff : diff;
    in_reach = (adiff <= $signed(YX_W'(CATCH_HALF_W)));
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    hold_d      = hold_q;
    catch_pulse = 1'b0;
    land_pulse  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      y_d     = '0;
      hold_d  = '0;
    end else if (!freeze) begin
      unique case (state_q)
        ST_IDLE: begin
          if (spawn) begin
            state_d = ST_FALL;
            y_d     = '0;
          end
        end
        ST_FALL: begin
          if (tick) begin
            // Catch test only fires on the tick that crosses the catch line.
            if (({1'b0, y_q} < CATCH_YX) && (ny >= CATCH_YX) && in_reach) begin
              state_d     = ST_CAUGHT;
              y_d         = Y_W'(CATCH_Y);
              hold_d      = '0;
              catch_pulse = 1'b1;
            end else if (ny >= FLOOR_YX) begin
              state_d    = ST_LANDED;
              y_d        = Y_W'(FLOOR_Y);
              hold_d     = '0;
              land_pulse = 1'b1;
            end else begin
              y_d = ny[Y_W-1:0];
            end
          end
        end
        default: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              state_d = ST_IDLE;
              y_d     = '0;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      hold_q  <= hold_d;
    end
  end

  assign state = state_q;
  assign y     = y_q;

endmodule

// File: rtl/parachute_obj_ctrl.sv
// Four-lane parachute object controller with registered catch/miss counts.
// Optional build macro PARACHUTE_SPEEDUP_EN raises the fall step every 8 catches.
module parachute_obj_ctrl
  import parachute_pkg::*;
#(
  parameter int FALL_STEP    = 2,
  parameter int CATCH_Y      = 420,
  parameter int FLOOR_Y      = 440,
  parameter int CATCH_HALF_W = 24,
  parameter int HOLD_FRAMES  = 30
) (
  input  logic               Clk,
  input  logic               Reset,
  parachute_obj_ctrl_if.slave bus
);

  logic [NUM_SLOTS-1:0] spawn;
  logic [NUM_SLOTS-1:0] catch_vec;
  logic [NUM_SLOTS-1:0] land_vec;
  logic [STEP_W-1:0]    step;
  obj_state_t           slot_state [NUM_SLOTS];
  logic [Y_W-1:0]       slot_y     [NUM_SLOTS];

  logic [2:0] score_add_q, score_add_d;
  logic [2:0] miss_add_q, miss_add_d;

  assign spawn = {bus.obj3, bus.obj2, bus.obj1, bus.obj0};

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    parachute_obj_slot #(
      .CATCH_Y      (CATCH_Y),
      .FLOOR_Y      (FLOOR_Y),
      .CATCH_HALF_W (CATCH_HALF_W),
      .HOLD_FRAMES  (HOLD_FRAMES)
    ) u_slot (
      .Clk         (Clk),
      .Reset       (Reset),
      .spawn       (spawn[gi]),
      .tick        (bus.frame_tick),
      .clear       (bus.obj_clear),
      .freeze      (bus.freeze),
      .step        (step),
      .lane_x      (LANE_X[gi]),
      .player_x    (bus.player_x),
      .state       (slot_state[gi]),
      .y           (slot_y[gi]),
      .catch_pulse (catch_vec[gi]),
      .land_pulse  (land_vec[gi])
    );

    assign bus.obj_state[2*gi +: 2]   = slot_state[gi];
    assign bus.obj_y[Y_W*gi +: Y_W]   = slot_y[gi];
  end

  // Slot pulses are already suppressed under clear/freeze.
  always_comb begin
    score_add_d = popcount4(catch_vec);
    miss_add_d  = popcount4(land_vec);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      score_add_q <= '0;
      miss_add_q  <= '0;
    end else begin
      score_add_q <= score_add_d;
      miss_add_q  <= miss_add_d;
    end
  end

  assign bus.score_add = score_add_q;
  assign bus.miss_add  = miss_add_q;

`ifdef PARACHUTE_SPEEDUP_EN
  logic [2:0]        catch_cnt_q, catch_cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [3:0]        catch_sum;

  // Bit 3 of the sum marks a wrap of the 3-bit catch counter.
  always_comb begin
    catch_sum   = {1'b0, catch_cnt_q} + {1'b0, score_add_q};
    catch_cnt_d = catch_sum[2:0];
    step_d      = step_q;
    if (bus.obj_clear) begin
      catch_cnt_d = '0;
      step_d      = STEP_W'(FALL_STEP);
    end else if (catch_sum[3] && (step_q < STEP_W'(MAX_STEP))) begin
      step_d = step_q + STEP_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      catch_cnt_q <= '0;
      step_q      <= STEP_W'(FALL_STEP);
    end else begin
      catch_cnt_q <= catch_cnt_d;
      step_q      <= step_d;
    end
  end

  assign step = step_q;
`else
  assign step = STEP_W'(FALL_STEP);
`endif

endmodule

// File: tb/tb_parachute_obj_ctrl.sv
// Scoreboard bench for parachute_obj_ctrl: cycle model pushes expectations, DUT output pops them.
module tb_parachute_obj_ctrl;
  import parachute_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  parachute_obj_ctrl_if bus ();

  parachute_obj_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  st;
    logic [39:0] y;
    logic [2:0]  sc;
    logic [2:0]  ms;
  } exp_t;

  exp_t sbq[$];

  int n_chk = 0;
  int n_fail = 0;
  int m_st[4];
  int m_y[4];
  int m_hold[4];
  int m_step = 2;
  int m_cnt = 0;
  int m_prev_sc = 0;
  int lane[4] = '{80, 240, 400, 560};
  logic clr_lvl = 1'b0;
  logic frz_lvl = 1'b0;
  int obs_sc = 0;
  int obs_ms = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] y_of(input int i);
    return bus.obj_y[10*i +: 10];
  endfunction

  function automatic logic [1:0] st_of(input int i);
    return bus.obj_state[2*i +: 2];
  endfunction

  task automatic model_step(input logic [3:0] sp, input logic tk, input int px);
    int sc;
    int ms;
    exp_t e;
    sc = 0;
    ms = 0;
    for (int i = 0; i < 4; i++) begin
      if (clr_lvl) begin
        m_st[i] = 0; m_y[i] = 0; m_hold[i] = 0;
      end else if (!frz_lvl) begin
        if (m_st[i] == 0) begin
          if (sp[i]) begin m_st[i] = 1; m_y[i] = 0; end
        end else if (m_st[i] == 1) begin
          if (tk) begin
            int ny;
            int d;
            ny = m_y[i] + m_step;
            d = lane[i] - px;
            if (d < 0) d = -d;
            if (m_y[i] < 420 && ny >= 420 && d <= 24) begin
              m_st[i] = 2; m_y[i] = 420; m_hold[i] = 0; sc++;
            end else if (ny >= 440) begin
              m_st[i] = 3; m_y[i] = 440; m_hold[i] = 0; ms++;
            end else begin
              m_y[i] = ny;
            end
          end
        end else if (tk) begin
          if (m_hold[i] == 29) begin
            m_st[i] = 0; m_y[i] = 0; m_hold[i] = 0;
          end else begin
            m_hold[i]++;
          end
        end
      end
    end
`ifdef PARACHUTE_SPEEDUP_EN
    if (clr_lvl) begin
      m_step = 2; m_cnt = 0;
    end else begin
      m_cnt += m_prev_sc;
      if (m_cnt >= 8) begin
        m_cnt -= 8;
        if (m_step < 6) m_step++;
      end
    end
`endif
    m_prev_sc = sc;
    e.st = '0;
    e.y = '0;
    for (int i = 0; i < 4; i++) begin
      e.st[2*i +: 2] = 2'(m_st[i]);
      e.y[10*i +: 10] = 10'(m_y[i]);
    end
    e.sc = 3'(sc);
    e.ms = 3'(ms);
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] sp, input logic tk);
    exp_t e;
    {bus.obj3, bus.obj2, bus.obj1, bus.obj0} = sp;
    bus.frame_tick = tk;
    bus.obj_clear = clr_lvl;
    bus.freeze = frz_lvl;
    model_step(sp, tk, int'(bus.player_x));
    @(posedge Clk);
    #1;
    e = sbq.pop_front();
    chk("sb_state", 64'(bus.obj_state), 64'(e.st));
    chk("sb_y", 64'(bus.obj_y), 64'(e.y));
    chk("sb_score", 64'(bus.score_add), 64'(e.sc));
    chk("sb_miss", 64'(bus.miss_add), 64'(e.ms));
    obs_sc += int'(bus.score_add);
    obs_ms += int'(bus.miss_add);
    {bus.obj3, bus.obj2, bus.obj1, bus.obj0} = 4'b0;
    bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(4'b0000, 1'b1);
      cyc(4'b0000, 1'b0);
    end
  endtask

  initial begin
    int exp_step;
    {bus.obj3, bus.obj2, bus.obj1, bus.obj0} = 4'b0;
    bus.frame_tick = 1'b0;
    bus.obj_clear = 1'b0;
    bus.freeze = 1'b0;
    bus.player_x = '0;

    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("rst_state", 64'(bus.obj_state), 64'd0);
    chk("rst_y", 64'(bus.obj_y), 64'd0);
    chk("rst_score", 64'(bus.score_add), 64'd0);
    chk("rst_miss", 64'(bus.miss_add), 64'd0);

    // Lane 1 catch
    bus.player_x = 10'd240;
    obs_sc = 0; obs_ms = 0;
    cyc(4'b0010, 1'b0);
    chk("t2_fall", 64'(st_of(1)), 64'd1);
    ticks(209);
    chk("t2_y209", 64'(y_of(1)), 64'd418);
    ticks(1);
    chk("t2_caught", 64'(st_of(1)), 64'd2);
    chk("t2_ycatch", 64'(y_of(1)), 64'd420);
    ticks(29);
    chk("t2_hold", 64'(st_of(1)), 64'd2);
    ticks(1);
    chk("t2_idle", 64'(st_of(1)), 64'd0);
    chk("t2_score_tot", 64'(obs_sc), 64'd1);

    // Lane 0 miss
    bus.player_x = 10'd400;
    obs_sc = 0; obs_ms = 0;
    cyc(4'b0001, 1'b0);
    ticks(210);
    chk("t3_nocatch", 64'(st_of(0)), 64'd1);
    ticks(9);
    chk("t3_y438", 64'(y_of(0)), 64'd438);
    ticks(1);
    chk("t3_landed", 64'(st_of(0)), 64'd3);
    chk("t3_yfloor", 64'(y_of(0)), 64'd440);
    chk("t3_miss_tot", 64'(obs_ms), 64'd1);
    chk("t3_score_tot", 64'(obs_sc), 64'd0);
    ticks(30);

    // Catch window edges on lane 2
    bus.player_x = 10'd376;
    cyc(4'b0100, 1'b0);
    ticks(210);
    chk("t4_diff24", 64'(st_of(2)), 64'd2);
    ticks(30);
    bus.player_x = 10'd375;
    cyc(4'b0100, 1'b0);
    ticks(210);
    chk("t4_diff25", 64'(st_of(2)), 64'd1);
    ticks(10);
    chk("t4_landed", 64'(st_of(2)), 64'd3);
    ticks(30);

    // All four lanes at once, spawn beats a coincident tick
    bus.player_x = 10'd400;
    obs_sc = 0; obs_ms = 0;
    cyc(4'b1111, 1'b1);
    chk("t5_allfall", 64'(bus.obj_state), 64'h55);
    chk("t5_ally0", 64'(bus.obj_y), 64'd0);
    ticks(100);
    cyc(4'b0100, 1'b0);
    chk("t5_respawn_y", 64'(y_of(2)), 64'd200);
    ticks(120);
    chk("t5_score_tot", 64'(obs_sc), 64'd1);
    chk("t5_miss_tot", 64'(obs_ms), 64'd3);
    chk("t5_states", 64'(bus.obj_state), 64'hEF);
    ticks(30);

    // Clear mid-fall, then freeze
    cyc(4'b1111, 1'b0);
    ticks(50);
    obs_sc = 0; obs_ms = 0;
    clr_lvl = 1'b1;
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b0);
    clr_lvl = 1'b0;
    chk("t6_clr_state", 64'(bus.obj_state), 64'd0);
    chk("t6_clr_y", 64'(bus.obj_y), 64'd0);
    chk("t6_clr_pulses", 64'(obs_sc + obs_ms), 64'd0);
    cyc(4'b0010, 1'b0);
    ticks(20);
    chk("t6_y40", 64'(y_of(1)), 64'd40);
    frz_lvl = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc(4'b0001, 1'b1);
      cyc(4'b0000, 1'b0);
    end
    frz_lvl = 1'b0;
    chk("t6_frz_y", 64'(y_of(1)), 64'd40);
    chk("t6_frz_spawn", 64'(st_of(0)), 64'd0);
    ticks(1);
    chk("t6_unfrz_y", 64'(y_of(1)), 64'd42);
    clr_lvl = 1'b1;
    cyc(4'b0000, 1'b0);
    clr_lvl = 1'b0;

    // Eight catches, then observe the next step size
    bus.player_x = 10'd240;
    obs_sc = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(4'b0010, 1'b0);
      ticks(240);
    end
    chk("t7_catches", 64'(obs_sc), 64'd8);
    cyc(4'b0010, 1'b0);
    ticks(1);
`ifdef PARACHUTE_SPEEDUP_EN
    exp_step = 3;
`else
    exp_step = 2;
`endif
    chk("t7_step", 64'(y_of(1)), 64'(exp_step));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/parachute_obj_ctrl.md
Name: parachute_obj_ctrl

Overview:
Consumer of the game-flow controller's spawn pulses (obj0..obj3). Owns four falling parachute objects, one per fixed lane. Advances each object once per video frame and detects a catch against the player's paddle X. Reports per-cycle catch and miss counts to the score logic, and exports object state and Y position to the sprite renderer.

Parameters:
FALL_STEP, 2, pixels an object descends per frame_tick (1..15)
CATCH_Y, 420, Y line at which the catch test is made
FLOOR_Y, 440, Y at which an uncaught object lands (> CATCH_Y)
CATCH_HALF_W, 24, max |lane_x - player_x| counted as a catch
HOLD_FRAMES, 30, frames an object stays in CAUGHT/LANDED before returning to IDLE

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (vsync edge)
obj0, obj1, obj2, obj3  in  1 each  one-cycle spawn pulses, lanes 0..3
obj_clear  in  1  level; while high, every slot is forced to IDLE (tie to timer_reset)
freeze  in  1  level; holds all slots (tie to game_over)
player_x  in  10  paddle centre X, pixels
obj_state  out  8  2 bits per slot (slot i at [2i+1:2i]): 0 IDLE, 1 FALL, 2 CAUGHT, 3 LANDED
obj_y  out  40  10 bits per slot (slot i at [10i+9:10i])
score_add  out  3  number of catches this cycle (0..4); valid for one cycle
miss_add  out  3  number of landings this cycle (0..4); valid for one cycle

Behaviour:
- Reset: every slot goes to IDLE with y=0. obj_state=0, obj_y=0, score_add=0, miss_add=0.
- Slot i has a fixed lane X: LANE_X = {80, 240, 400, 560}.
- Priority per slot, highest first: Reset, obj_clear, freeze, spawn, frame_tick.
  - obj_clear: slot goes to IDLE, y=0, hold counter=0. No score or miss is generated.
  - freeze: no state, y or counter change. Spawns are dropped. score_add and miss_add are 0.
- IDLE: a spawn pulse sets y=0 and moves to FALL on the next edge. If spawn and frame_tick arrive in the same cycle, the spawn wins; no move on that tick.
- Spawn while the slot is not IDLE: ignored; the object is not restarted.
- FALL, on frame_tick, with ny = y + FALL_STEP (11-bit compute):
  - Catch: y < CATCH_Y and ny >= CATCH_Y and |LANE_X[i] - player_x| <= CATCH_HALF_W. Then y = CATCH_Y, state = CAUGHT, and the slot contributes 1 to score_add.
  - Landing (otherwise): if ny >= FLOOR_Y, then y = FLOOR_Y, state = LANDED, and the slot contributes 1 to miss_add.
  - Otherwise: y = ny.
  - A missed object that has passed CATCH_Y is never re-tested.
- CAUGHT / LANDED: the hold counter increments on each frame_tick. When it reaches HOLD_FRAMES-1 on a tick, the slot goes to IDLE with y=0 and counter=0.
- score_add and miss_add are registered: asserted the cycle after the deciding frame_tick edge, for exactly one cycle. They are the popcount of all slots resolving on that tick; simultaneous events are never lost.
- obj_state and obj_y are registered copies of the slot registers. Latency from spawn to FALL is 1 cycle.
- Absolute difference is computed in 11-bit signed arithmetic; player_x is unclipped.

Optional Feature:
Macro: PARACHUTE_SPEEDUP_EN.
- With the macro: a 3-bit catch counter accumulates score_add. Each time it wraps (8 catches), the effective step increases by 1, to a maximum of 6. The step resets to FALL_STEP on Reset or obj_clear. The step change takes effect on the frame_tick after the wrap.
- Without the macro: the step is constant at FALL_STEP and no counter logic is present.

Decomposition:
- Package parachute_pkg holds:
  - obj_state_t (2-bit enum IDLE/FALL/CAUGHT/LANDED)
  - LANE_X array
  - Y width constant (10)
  - MAX_STEP (6)
- Sub-module parachute_obj_slot is one slot FSM: inputs are spawn, tick, clear, freeze, step, lane_x and player_x; outputs are state, y, catch_pulse and land_pulse. It is instantiated 4 times. The top level handles the popcount, output registers and speedup logic.

Test Plan:
1. Reset high 2 cycles, then low -> obj_state=0, obj_y=0, score_add=0, miss_add=0.
2. player_x=240, pulse obj1, then 210 frame_ticks -> slot1 FALL with y=2k, CAUGHT at tick 210 with y=420; score_add=1 for one cycle; IDLE 30 ticks later.
3. player_x=400, pulse obj0 -> no catch at tick 210; LANDED at tick 220 with y=440; miss_add=1.
4. Lane 2 with player_x=376 (diff 24) -> caught. Repeat with player_x=375 (diff 25) -> landed.
5. Pulse obj0..obj3 in the same cycle with player_x=400, then tick -> only slot2 caught and 3 landed: score_add=1 and miss_add=3 on their respective cycles. A spawn of obj2 mid-fall leaves y unchanged.
6. obj_clear mid-fall -> all IDLE, y=0, no score/miss pulse. freeze for 50 ticks -> y unchanged and spawn ignored. With PARACHUTE_SPEEDUP_EN, 8 catches -> the next fall steps by 3.
